// File: rtl/stream_light_pkg.sv
// Shared definitions for the stream-light button front-end.
//   run_state_t             : run/stop mode held by the conditioner FSM
//   DEBOUNCE_CYCLES_DEFAULT : 20 ms debounce window at 100 MHz
//   SIM_DEBOUNCE_CYCLES     : short debounce window for simulation
package stream_light_pkg;

    typedef enum logic {
        STOPPED = 1'b0,
        RUNNING = 1'b1
    } run_state_t;

    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 2000000;
    localparam int unsigned SIM_DEBOUNCE_CYCLES     = 4;

endpackage

// File: rtl/button_debounce.sv
// Single push-button conditioner: 2-flop synchroniser, integrating debounce
// counter and one-cycle press pulse.
//   CLK         : system clock, rising edge
//   Reset       : asynchronous active-low reset
//   btn_in      : raw asynchronous button level
//   level       : accepted (debounced) button level
//   press_pulse : one-cycle pulse when the accepted level rises 0->1
module button_debounce
    import stream_light_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int unsigned CNT_W           = 21
) (
    input  logic CLK,
    input  logic Reset,
    input  logic btn_in,
    output logic level,
    output logic press_pulse
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             acc;
    logic [CNT_W-1:0] cnt;
    logic             pulse;

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            acc   <= 1'b0;
            cnt   <= '0;
            pulse <= 1'b0;
        end else begin
            sync1 <= btn_in;
            sync2 <= sync1;
            pulse <= 1'b0;
            if (sync2 == acc) begin
                // Any return to agreement discards the partial count.
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                acc   <= sync2;
                cnt   <= '0;
                // Pulse only on acceptance of a press, never a release.
                pulse <= sync2;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign level       = acc;
    assign press_pulse = pulse;

endmodule

// File: rtl/stream_light_button_conditioner.sv
// Front-end for the stream-light LED controller. Debounces the Reverse,
// Stop and Run buttons, emits one-cycle press pulses and holds the
// run/stop mode and shift direction.
//   CLK           : system clock, rising edge
//   Reset         : asynchronous active-low reset
//   Reverse_btn   : raw Reverse button
//   Stop_btn      : raw Stop button
//   Run_btn       : raw Run button
//   Reverse_pulse : one-cycle pulse on accepted Reverse press
//   Stop_pulse    : one-cycle pulse on accepted Stop press
//   Run_pulse     : one-cycle pulse on accepted Run press
//   Enable        : 1 = RUNNING, 0 = STOPPED
//   Dir           : 0 = forward, 1 = reverse
module stream_light_button_conditioner
    import stream_light_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int unsigned CNT_W           = 21
) (
    input  logic CLK,
    input  logic Reset,
    input  logic Reverse_btn,
    input  logic Stop_btn,
    input  logic Run_btn,
    output logic Reverse_pulse,
    output logic Stop_pulse,
    output logic Run_pulse,
    output logic Enable,
    output logic Dir
);

    // Accepted levels are not needed here; the LED stage only uses pulses.
    logic [2:0] unused_levels;

    run_state_t state_q;
    run_state_t state_d;
    logic       dir_q;
    logic       dir_d;

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_reverse (
        .CLK        (CLK),
        .Reset      (Reset),
        .btn_in     (Reverse_btn),
        .level      (unused_levels[2]),
        .press_pulse(Reverse_pulse)
    );

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_stop (
        .CLK        (CLK),
        .Reset      (Reset),
        .btn_in     (Stop_btn),
        .level      (unused_levels[1]),
        .press_pulse(Stop_pulse)
    );

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_run (
        .CLK        (CLK),
        .Reset      (Reset),
        .btn_in     (Run_btn),
        .level      (unused_levels[0]),
        .press_pulse(Run_pulse)
    );

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q <= STOPPED;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        if (state_q == STOPPED && Run_pulse) begin
            state_d = RUNNING;
        end
        // Stop is evaluated last so it wins over a coincident Run.
        if (Stop_pulse) begin
            state_d = STOPPED;
        end
        if (Reverse_pulse) begin
            dir_d = ~dir_q;
        end
    end

    assign Enable = (state_q == RUNNING);
    assign Dir    = dir_q;

endmodule

// File: tb/tb_stream_light_button_conditioner.sv
module tb_stream_light_button_conditioner;
    import stream_light_pkg::*;

    logic CLK = 1'b0;
    logic Reset = 1'b0;
    logic Reverse_btn = 1'b0;
    logic Stop_btn = 1'b0;
    logic Run_btn = 1'b0;
    logic Reverse_pulse;
    logic Stop_pulse;
    logic Run_pulse;
    logic Enable;
    logic Dir;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    typedef struct {
        logic [2:0] p;      // {reverse, stop, run}
        int         cyc;
        logic       epre;
        logic       dpre;
        logic       epost;
        logic       dpost;
    } exp_t;

    exp_t q[$];
    exp_t e;
    logic [2:0] obs;

    stream_light_button_conditioner #(
        .DEBOUNCE_CYCLES(SIM_DEBOUNCE_CYCLES),
        .CNT_W          (3)
    ) dut (
        .CLK          (CLK),
        .Reset        (Reset),
        .Reverse_btn  (Reverse_btn),
        .Stop_btn     (Stop_btn),
        .Run_btn      (Run_btn),
        .Reverse_pulse(Reverse_pulse),
        .Stop_pulse   (Stop_pulse),
        .Run_pulse    (Run_pulse),
        .Enable       (Enable),
        .Dir          (Dir)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic void check(string name, int act, int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitor: every observed pulse must match the head of the queue.
    initial begin
        forever begin
            @(negedge CLK);
            obs = {Reverse_pulse, Stop_pulse, Run_pulse};
            if (obs != 3'b000) begin
                if (q.size() == 0) begin
                    check("unexpected_pulse", int'(obs), 0);
                end else begin
                    e = q.pop_front();
                    check("pulses", int'(obs), int'(e.p));
                    check("pulse_cycle", cyc, e.cyc);
                    check("enable_at_pulse", int'(Enable), int'(e.epre));
                    check("dir_at_pulse", int'(Dir), int'(e.dpre));
                    @(negedge CLK);
                    check("pulse_width", int'({Reverse_pulse, Stop_pulse, Run_pulse}), 0);
                    check("enable_after", int'(Enable), int'(e.epost));
                    check("dir_after", int'(Dir), int'(e.dpost));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic expect_pulse(input logic [2:0] p, input int at,
                                input logic epre, input logic dpre,
                                input logic epost, input logic dpost);
        exp_t x;
        x.p = p; x.cyc = at;
        x.epre = epre; x.dpre = dpre; x.epost = epost; x.dpost = dpost;
        q.push_back(x);
    endtask

    task automatic set_btns(input logic [2:0] b);
        {Reverse_btn, Stop_btn, Run_btn} = b;
    endtask

    // Press with pulse expected 6 cycles after the driving negedge.
    task automatic press(input logic [2:0] b, input int hold, input logic [2:0] ep,
                         input logic epre, input logic dpre,
                         input logic epost, input logic dpost);
        @(negedge CLK);
        set_btns(b);
        expect_pulse(ep, cyc + 6, epre, dpre, epost, dpost);
        repeat (hold) @(negedge CLK);
        set_btns(3'b000);
        repeat (10) @(negedge CLK);
    endtask

    task automatic glitch_run(input logic [7:0] pat, input int len);
        for (int i = 0; i < len; i++) begin
            @(negedge CLK);
            Run_btn = pat[i];
        end
        @(negedge CLK);
        Run_btn = 1'b0;
        repeat (12) @(negedge CLK);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge CLK);
        check("rst_enable", int'(Enable), 0);
        check("rst_dir", int'(Dir), 0);
        check("rst_pulses", int'({Reverse_pulse, Stop_pulse, Run_pulse}), 0);
        Reset = 1'b1;
        repeat (3) @(negedge CLK);

        // Glitches shorter than the debounce window
        glitch_run(8'b0000_0111, 3);
        glitch_run(8'b0000_1101, 5);
        check("glitch_enable", int'(Enable), 0);

        // Run held: single pulse, Enable rises
        press(3'b001, 20, 3'b001, 1'b0, 1'b0, 1'b1, 1'b0);
        check("held_enable", int'(Enable), 1);

        // Reverse twice while running
        press(3'b100, 8, 3'b100, 1'b1, 1'b0, 1'b1, 1'b1);
        press(3'b100, 8, 3'b100, 1'b1, 1'b1, 1'b1, 1'b0);

        // Stop and Run together: Stop wins
        press(3'b011, 8, 3'b011, 1'b1, 1'b0, 1'b0, 1'b0);

        // Stop while stopped: no change
        press(3'b010, 8, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0);

        // Run, then Run while running: no change
        press(3'b001, 8, 3'b001, 1'b0, 1'b0, 1'b1, 1'b0);
        press(3'b001, 8, 3'b001, 1'b1, 1'b0, 1'b1, 1'b0);

        // Reverse to Dir=1 while running
        press(3'b100, 8, 3'b100, 1'b1, 1'b0, 1'b1, 1'b1);
        check("pre_rst_enable", int'(Enable), 1);
        check("pre_rst_dir", int'(Dir), 1);

        // Reset mid-count with Reverse held
        @(negedge CLK);
        Reverse_btn = 1'b1;
        repeat (4) @(negedge CLK);
        Reset = 1'b0;
        #1;
        check("midrst_enable", int'(Enable), 0);
        check("midrst_dir", int'(Dir), 0);
        check("midrst_pulses", int'({Reverse_pulse, Stop_pulse, Run_pulse}), 0);
        repeat (3) @(negedge CLK);
        Reset = 1'b1;
        expect_pulse(3'b100, cyc + 6, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (12) @(negedge CLK);
        Reverse_btn = 1'b0;
        repeat (12) @(negedge CLK);

        check("queue_empty", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/stream_light_button_conditioner.md
Name: stream_light_button_conditioner

Overview:
- Upstream front-end for the stream-light LED controller.
- Takes the three raw, bouncing, asynchronous push-buttons (Reverse, Stop, Run).
- Synchronises and debounces each button, then emits one-cycle press pulses.
- Holds the run/stop and direction mode in a small FSM, so the LED stage sees clean, glitch-free control.

Parameters:
- DEBOUNCE_CYCLES, 2000000, number of consecutive clock cycles a synchronised level must differ from the accepted level before it is accepted (20 ms at 100 MHz). Legal range is at least 2.
- CNT_W, 21, width of each debounce counter. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- CLK  input  1  system clock; all state updates on its rising edge.
- Reset  input  1  asynchronous, active-low reset. 0 clears all state immediately; release is synchronised by the integrator at top level.
- Reverse_btn  input  1  raw Reverse button, asynchronous, may bounce.
- Stop_btn  input  1  raw Stop button, asynchronous, may bounce.
- Run_btn  input  1  raw Run button, asynchronous, may bounce.
- Reverse_pulse  output  1  one-cycle pulse on an accepted Reverse press (0→1).
- Stop_pulse  output  1  one-cycle pulse on an accepted Stop press.
- Run_pulse  output  1  one-cycle pulse on an accepted Run press.
- Enable  output  1  1 = LEDs stepping (RUNNING), 0 = frozen (STOPPED).
- Dir  output  1  0 = forward shift, 1 = reverse shift.

Behaviour:
- Reset (Reset=0, async): all synchronisers, accepted levels, counters and pulses go to 0. FSM goes to STOPPED, Enable=0, Dir=0.
  - A button held during reset is accepted only after the full debounce time following release, then produces its pulse.
- Per button, synchroniser: 2-flop chain sync1→sync2. Only sync2 is used downstream.
- Per button, debounce:
  - Registers acc (accepted level) and cnt.
  - If sync2==acc: cnt←0.
  - Else if cnt==DEBOUNCE_CYCLES-1: acc←sync2, cnt←0.
  - Else: cnt←cnt+1.
  - Any return to agreement before acceptance discards the count. There is no partial credit.
- Pulse:
  - The pulse register is set to 1 on the same edge acc goes 0→1, and cleared on the next edge. It is exactly one cycle wide.
  - A release (1→0 acceptance) produces no pulse.
  - A held button produces exactly one pulse.
- Latency: an input change first sampled at edge 0 yields acc and pulse high after edge DEBOUNCE_CYCLES+1.
- FSM states: STOPPED, RUNNING.
  - STOPPED + Run_pulse → RUNNING.
  - RUNNING + Stop_pulse → STOPPED.
  - Stop_pulse in STOPPED and Run_pulse in RUNNING: no change.
  - Simultaneous Run_pulse and Stop_pulse: Stop wins, result is STOPPED.
- Dir toggles on every Reverse_pulse, in either state. Reverse concurrent with Run or Stop is applied independently in the same edge.
- Enable = (state==RUNNING), registered. Enable and Dir change on the edge after the causing pulse is high, i.e. one cycle after the pulse.
- The three buttons are fully independent. No priority or arbitration exists except the FSM rule above.
- Counters never wrap: cnt is bounded by DEBOUNCE_CYCLES-1 by construction.

Decomposition:
- Shared package stream_light_pkg holds:
  - typedef run_state_t {STOPPED, RUNNING};
  - constant DEBOUNCE_CYCLES_DEFAULT = 2000000;
  - constant SIM_DEBOUNCE_CYCLES = 4.
- Sub-module button_debounce (params DEBOUNCE_CYCLES, CNT_W; ports CLK, Reset, btn_in, level, press_pulse) contains the synchroniser, counter and pulse logic. It is instantiated three times.
- The FSM lives in the top of this block.

Test Plan (DEBOUNCE_CYCLES=4, CNT_W=3):
- Reset, then Run_btn=1 held from edge 0 → Run_pulse=1 for exactly one cycle after edge 5. Enable=1 after edge 6 and stays 1 while held; no second pulse.
- Run_btn glitches high for 3 cycles, then 0 → no Run_pulse; Enable stays 0. Repeat with bounce 1-0-1-1-0 → still no pulse.
- RUNNING, Reverse pressed twice (each held ≥6 cycles, released ≥6 cycles) → two pulses; Dir goes 0→1→0; Enable stays 1 throughout.
- RUNNING, Stop_btn and Run_btn rise on the same cycle → both pulses coincide after edge 5; state=STOPPED, Enable=0 after edge 6.
- Reset asserted mid-count (cnt=2) and while RUNNING with Dir=1 → immediately Enable=0, Dir=0, all pulses 0. After release with button still held → pulse appears only after edge 5 counted from release.
- Stop_pulse while STOPPED, and Run_pulse while RUNNING → state, Enable and Dir unchanged.
